// File: rtl/mc_pkg.sv
// mc_pkg: shared encodings for the multicycle controller.
// States, mux selects, ALU codes, condition codes, ALU decode.
package mc_pkg;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b100;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCB_WD   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [3:0] C_EQ = 4'h0;
  localparam logic [3:0] C_NE = 4'h1;
  localparam logic [3:0] C_CS = 4'h2;
  localparam logic [3:0] C_CC = 4'h3;
  localparam logic [3:0] C_MI = 4'h4;
  localparam logic [3:0] C_PL = 4'h5;
  localparam logic [3:0] C_VS = 4'h6;
  localparam logic [3:0] C_VC = 4'h7;
  localparam logic [3:0] C_HI = 4'h8;
  localparam logic [3:0] C_LS = 4'h9;
  localparam logic [3:0] C_GE = 4'ha;
  localparam logic [3:0] C_LT = 4'hb;
  localparam logic [3:0] C_GT = 4'hc;
  localparam logic [3:0] C_LE = 4'hd;
  localparam logic [3:0] C_AL = 4'he;
  localparam logic [3:0] C_NV = 4'hf;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  typedef struct packed {
    logic [2:0] ctl;
    logic [1:0] flagw;
    logic       cmp;
  } alu_dec_t;

  function automatic alu_dec_t alu_decode(
    input logic [3:0] cmd,
    input logic       s
  );
    alu_dec_t d;
    d.ctl   = ALU_ADD;
    d.flagw = 2'b00;
    d.cmp   = 1'b0;
    case (cmd)
      CMD_ADD: d.flagw = s ? 2'b11 : 2'b00;
      CMD_SUB: begin
        d.ctl   = ALU_SUB;
        d.flagw = s ? 2'b11 : 2'b00;
      end
      CMD_AND: begin
        d.ctl   = ALU_AND;
        d.flagw = s ? 2'b10 : 2'b00;
      end
      CMD_ORR: begin
        d.ctl   = ALU_ORR;
        d.flagw = s ? 2'b10 : 2'b00;
      end
      CMD_EOR: begin
        d.ctl   = ALU_EOR;
        d.flagw = s ? 2'b10 : 2'b00;
      end
      // CMP without S is not a real encoding; it falls back to ADD
      CMD_CMP: begin
        if (s) begin
          d.ctl   = ALU_SUB;
          d.flagw = 2'b11;
          d.cmp   = 1'b1;
        end
      end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mc_cond_check.sv
// cond_check: ARM condition evaluation from registered NZCV.
// Code 1111 is treated as always.
module cond_check
  import mc_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       cond_ex
);

  logic n, z, c, v;

  assign {n, z, c, v} = nzcv;

  always_comb begin
    cond_ex = 1'b1;
    case (cond)
      C_EQ: cond_ex = z;
      C_NE: cond_ex = !z;
      C_CS: cond_ex = c;
      C_CC: cond_ex = !c;
      C_MI: cond_ex = n;
      C_PL: cond_ex = !n;
      C_VS: cond_ex = v;
      C_VC: cond_ex = !v;
      C_HI: cond_ex = c && !z;
      C_LS: cond_ex = !c || z;
      C_GE: cond_ex = n == v;
      C_LT: cond_ex = n != v;
      C_GT: cond_ex = !z && (n == v);
      C_LE: cond_ex = z || (n != v);
      default: cond_ex = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// mc_controller: multicycle ARM-subset control FSM with
// condition gating, NZCV flags and a memory wait timeout.
module mc_controller
  import mc_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Instr,
  input  logic [3:0]  Flags,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        MemWrite,
  output logic        AdrSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic [2:0]  ALUControl,
  output logic        mem_err,
  output logic [3:0]  state
);

  localparam logic [7:0] LIMIT = 8'(MAX_WAIT);

  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] nzcv;
  logic [7:0] cnt;
  logic [3:0] nxt;
  logic       cond_ex;
  logic       waiting;
  logic       timeout;
  logic       unused_bits;
  alu_dec_t   dec;

  assign op    = Instr[27:26];
  assign funct = Instr[25:20];
  assign rd    = Instr[15:12];
  assign dec   = alu_decode(funct[4:1], funct[0]);

  assign unused_bits = ^{Instr[19:16], Instr[11:0]};

  cond_check u_cond (
    .cond    (Instr[31:28]),
    .nzcv    (nzcv),
    .cond_ex (cond_ex)
  );

  assign waiting = !mem_ready &&
    (state == S_FETCH || state == S_MEMREAD ||
     state == S_MEMWRITE);

  // mem_ready in the limit cycle means waiting is 0: ready wins
  assign timeout = (LIMIT != 8'd0) && waiting &&
    (cnt == LIMIT);

  always_comb begin
    nxt = state;
    case (state)
      S_FETCH: if (mem_ready) nxt = S_DECODE;
      S_DECODE: begin
        if (!cond_ex)
          nxt = S_FETCH;
        else if (op == 2'b01)
          nxt = S_MEMADR;
        else if (op == 2'b00)
          nxt = funct[5] ? S_EXECI : S_EXECR;
        else if (op == 2'b10)
          nxt = S_BRANCH;
        else
          nxt = S_FETCH;
      end
      S_MEMADR:
        nxt = funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: if (mem_ready) nxt = S_MEMWB;
      S_MEMWRITE: if (mem_ready) nxt = S_FETCH;
      S_EXECR, S_EXECI: nxt = S_ALUWB;
      default: nxt = S_FETCH;
    endcase
    if (timeout) nxt = S_FETCH;
  end

  always_comb begin
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_WD;
    ResultSrc  = RES_ALUOUT;
    ALUControl = ALU_ADD;
    case (state)
      S_FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURES;
      end
      S_MEMADR: ALUSrcB = SRCB_IMM;
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = !timeout;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
        PCWrite   = rd == 4'd15;
      end
      S_EXECR: ALUControl = dec.ctl;
      S_EXECI: begin
        ALUSrcB    = SRCB_IMM;
        ALUControl = dec.ctl;
      end
      S_ALUWB: begin
        ALUControl = dec.ctl;
        RegWrite   = !dec.cmp;
        PCWrite    = (rd == 4'd15) && !dec.cmp;
      end
      S_BRANCH: begin
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURES;
        PCWrite   = 1'b1;
      end
      default: ;
    endcase
  end

  assign ImmSrc  = op;
  assign RegSrc  = {op == 2'b01 && !funct[0], op == 2'b10};
  assign mem_err = timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
      nzcv  <= 4'b0000;
      cnt   <= 8'd0;
    end else begin
      state <= nxt;
      if (nxt != state || timeout)
        cnt <= 8'd0;
      else if (waiting && cnt != 8'hff)
        cnt <= cnt + 8'd1;
      if (state == S_EXECR || state == S_EXECI) begin
        if (dec.flagw[1]) nzcv[3:2] <= Flags[3:2];
        if (dec.flagw[0]) nzcv[1:0] <= Flags[1:0];
      end
    end
  end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15 (range 0..255); memory wait limit in cycles; 0 disables the timeout.
REQ-002 SHALL have port clk, input, 1 bit; the single clock, rising edge active.
REQ-003 SHALL have port rst_n, input, 1 bit; reset, asynchronous, active-low.
REQ-004 SHALL have port Instr, input, 32 bits; instruction register contents.
REQ-005 SHALL have port Flags, input, 4 bits; ALU NZCV result for the current cycle.
REQ-006 SHALL have port mem_ready, input, 1 bit; shared instruction/data memory access completes this cycle.
REQ-007 SHALL have outputs PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc and ALUSrcA, 1 bit each; AdrSrc 0=PC, 1=Result; ALUSrcA 0=Rn, 1=PC.
REQ-008 SHALL have outputs ALUSrcB, ResultSrc, ImmSrc and RegSrc, 2 bits each; ALUSrcB 00=WriteData, 01=ExtImm, 10=constant 4; ResultSrc 00=ALUOut, 01=Data, 10=ALUResult.
REQ-009 SHALL have output ALUControl, 3 bits: 000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR.
REQ-010 SHALL have output mem_err, 1 bit, a timeout pulse, and output state, 4 bits, the current FSM state for debug.

Function
REQ-011 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB and BRANCH; all outputs SHALL be combinational from state, registered flags, Instr and mem_ready.
REQ-012 SHALL decode fields as Cond=Instr[31:28], Op=Instr[27:26], Funct=Instr[25:20], Rd=Instr[15:12]; ImmSrc=Op; RegSrc[1]=(Op==01 && !Funct[0]); RegSrc[0]=(Op==10).
REQ-013 In FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10; IRWrite and PCWrite SHALL be 1 only while mem_ready=1; go to DECODE on mem_ready, otherwise hold.
REQ-014 In DECODE: ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10.
REQ-015 DECODE exits: CondEx=0 -> FETCH; Op=01 -> MEMADR; Op=00 with Funct[5]=0 -> EXECR; Op=00 with Funct[5]=1 -> EXECI; Op=10 -> BRANCH; Op=11 -> FETCH.
REQ-016 In MEMADR: ALUSrcA=0, ALUSrcB=01, ADD; go to MEMREAD if Funct[0]=1, else MEMWRITE.
REQ-017 In MEMREAD: AdrSrc=1, ResultSrc=00; go to MEMWB on mem_ready.
REQ-018 In MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1 held; go to FETCH on mem_ready.
REQ-019 In MEMWB: ResultSrc=01, RegWrite=1, PCWrite=(Rd==15); then go to FETCH.
REQ-020 In EXECR: ALUSrcA=0, ALUSrcB=00; EXECI is identical except ALUSrcB=01; both go to ALUWB.
REQ-021 ALU decode on {Funct[4:1],S} SHALL be: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 0001 EOR, 1010 with S=1 CMP (SUB, no write); any other code SHALL decode as ADD with no flag update.
REQ-022 FlagW SHALL be 11 for ADDS/SUBS/CMP, 10 for ANDS/ORRS/EORS, and 00 otherwise.
REQ-023 In ALUWB: ResultSrc=00; RegWrite=1 except for CMP; PCWrite=(Rd==15 && not CMP); then go to FETCH.
REQ-024 In BRANCH: ALUSrcA=0, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=1; then go to FETCH.
REQ-025 NZCV registers SHALL load from Flags on the clock edge ending EXECR/EXECI; N and Z when FlagW[1]=1, C and V when FlagW[0]=1.
REQ-026 CondEx SHALL be evaluated in DECODE from the registered NZCV using the standard 16-code ARM condition table; code 1111 SHALL be treated as always.
REQ-027 A wait counter (8 bits) SHALL count cycles spent in FETCH, MEMREAD or MEMWRITE with mem_ready=0, and SHALL clear on any state change.
REQ-028 When MAX_WAIT≠0 and the count reaches MAX_WAIT, mem_err SHALL pulse for 1 cycle, the state SHALL go to FETCH, and no RegWrite/MemWrite/PCWrite/IRWrite SHALL be asserted that cycle.
REQ-029 If mem_ready=1 occurs in the same cycle the timeout is reached, mem_ready SHALL win and no mem_err SHALL be raised.
REQ-030 In all states, all strobes not listed for that state SHALL be 0, and mem_err SHALL be 0 except during the timeout pulse.

Reset
REQ-031 While rst_n=0: state=FETCH, NZCV=0000, wait counter=0, mem_err=0, with immediate (asynchronous) effect, including mid-access.
REQ-032 Immediately after reset, with mem_ready=0, all strobes SHALL be 0.

Structure
REQ-033 State encodings, ALUControl codes, ResultSrc/ALUSrcB codes and condition codes SHALL live in shared package mc_pkg.
REQ-034 Condition evaluation SHALL be the combinational sub-module cond_check (inputs Cond and NZCV, output CondEx).

Verification
REQ-035 ADD R1,R2,R3 (0xE0821003), mem_ready=1: states SHALL be FETCH, DECODE, EXECR, ALUWB; RegWrite=1 only in ALUWB; ALUControl=000.
REQ-036 SUBS (0xE0520003) with Flags=0100, then BEQ (0x0A000002): Z=1 and BRANCH SHALL give PCWrite=1; repeating with Flags=0000 SHALL give DECODE->FETCH and no branch PCWrite.
REQ-037 CMP R1,R2 (0xE1510002): ALUWB SHALL have RegWrite=0, ALUControl=001, and NZCV updated.
REQ-038 LDR (0xE5910004) with mem_ready low for 3 cycles in MEMREAD: MEMREAD SHALL be held 4 cycles, followed by MEMWB with RegWrite=1 for 1 cycle.
REQ-039 MAX_WAIT=4, STR (0xE5810000), mem_ready=0: MemWrite SHALL stay high 4 cycles, then mem_err pulses once, state returns to FETCH, and RegWrite is never asserted.
REQ-040 rst_n low mid-MEMWRITE: MemWrite SHALL drop the same cycle, state=FETCH, NZCV=0000.
